// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - N-way fixed-priority / round-robin arbiter with a per-owner hold limit
module priority_arbiter #(
  parameter int N        = 4,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  grant_nxt;
  logic [IW-1:0] grant_id_nxt;
  logic          busy_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic [IW-1:0] last_id, last_id_nxt;

  logic [N-1:0]  cand;
  logic [IW-1:0] start;
  logic [IW-1:0] winner;
  logic          found;
  logic          owner_req;
  logic          others;
  logic          limit_hit;
  logic          take_new;
  int            idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      last_id  <= IW'(N - 1);
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      busy     <= busy_nxt;
      hold_cnt <= hold_cnt_nxt;
      last_id  <= last_id_nxt;
    end
  end

  always_comb begin
    owner_req = req[grant_id] && (state == GRANT);
    others    = |(req & ~grant);
    limit_hit = (MAX_HOLD != 0) && (int'(hold_cnt) == MAX_HOLD - 1);

    // A forced re-arbitration excludes the current owner from the candidates.
    cand = req;
    if (owner_req) cand = req & ~grant;

    start = '0;
    if (RR_MODE != 0) start = (int'(last_id) == N - 1) ? '0 : last_id + IW'(1);

    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    busy_nxt     = busy;
    hold_cnt_nxt = hold_cnt;
    last_id_nxt  = last_id;
    take_new     = 1'b0;

    case (state)
      IDLE: begin
        if (found) take_new = 1'b1;
      end
      GRANT: begin
        if (owner_req && !(limit_hit && others)) begin
          // Limit reached with nobody waiting: the owner simply starts a fresh hold window.
          if (limit_hit)                        hold_cnt_nxt = '0;
          else if (int'(hold_cnt) < MAX_HOLD)   hold_cnt_nxt = hold_cnt + HW'(1);
        end else if (found) begin
          take_new = 1'b1;
        end else begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          grant_id_nxt = '0;
          busy_nxt     = 1'b0;
          hold_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (take_new) begin
      state_nxt    = GRANT;
      grant_nxt    = {{(N-1){1'b0}}, 1'b1} << winner;
      grant_id_nxt = winner;
      busy_nxt     = 1'b1;
      hold_cnt_nxt = '0;
      last_id_nxt  = winner;
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - self-checking bench for priority_arbiter in fixed and round-robin modes
module tb_priority_arbiter;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] g_fix, g_rr;
  logic [1:0] id_fix, id_rr;
  logic       b_fix, b_rr;

  int checks;
  int failures;

  int owner [2];
  int held  [2];
  int last  [2];

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_fix;
    logic [3:0] exp_rr;
  } vec_t;

  vec_t tbl [11];

  priority_arbiter #(.N(4), .RR_MODE(0), .MAX_HOLD(MAXH)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(g_fix), .grant_id(id_fix), .busy(b_fix)
  );

  priority_arbiter #(.N(4), .RR_MODE(1), .MAX_HOLD(MAXH)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(g_rr), .grant_id(id_rr), .busy(b_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int first);
    for (int k = 0; k < 4; k++) begin
      if (r[(first + k) % 4]) return (first + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1;
      held[m]  = 0;
      last[m]  = 3;
    end
  endtask

  // held[m] = number of grant cycles the current owner has had, counting the present one.
  task automatic model_step(input logic [3:0] r);
    for (int m = 0; m < 2; m++) begin
      int w;
      logic [3:0] rest;
      w = -1;
      if (owner[m] < 0) begin
        w = pick(r, (m == 1) ? (last[m] + 1) % 4 : 0);
      end else if (r[owner[m]]) begin
        rest = r & ~(4'b0001 << owner[m]);
        if (held[m] >= MAXH && rest != 4'b0000) w = pick(rest, (m == 1) ? (owner[m] + 1) % 4 : 0);
        else if (held[m] >= MAXH)               held[m] = 1;
        else                                    held[m] = held[m] + 1;
      end else begin
        w = pick(r, (m == 1) ? (last[m] + 1) % 4 : 0);
        if (w < 0) begin
          owner[m] = -1;
          held[m]  = 0;
        end
      end
      if (w >= 0) begin
        owner[m] = w;
        held[m]  = 1;
        last[m]  = w;
      end
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      logic [3:0] g, eg;
      logic [1:0] id, eid;
      logic       b;
      g  = (m == 0) ? g_fix  : g_rr;
      id = (m == 0) ? id_fix : id_rr;
      b  = (m == 0) ? b_fix  : b_rr;
      eg  = (owner[m] < 0) ? 4'b0000 : 4'(1 << owner[m]);
      eid = (owner[m] < 0) ? 2'd0 : 2'(owner[m]);
      chk((m == 0) ? "fix_grant" : "rr_grant", 32'(g), 32'(eg));
      chk((m == 0) ? "fix_grant_id" : "rr_grant_id", 32'(id), 32'(eid));
      chk((m == 0) ? "fix_busy" : "rr_busy", 32'(b), 32'(owner[m] >= 0));
      chk((m == 0) ? "fix_onehot" : "rr_onehot", 32'($onehot0(g)), 32'd1);
      chk((m == 0) ? "fix_id_consistent" : "rr_id_consistent",
          32'((g == 4'b0000) ? (id == 2'd0) : g[id]), 32'd1);
    end
  endtask

  // Called just after a falling edge: drive req, let one rising edge pass, compare at the next falling edge.
  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [3:0] r;
    int exp_rr_seq [5];
    logic [3:0] rr_req_seq [5];

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    model_reset();

    tbl[0]  = '{4'b0110, 4'b0010, 4'b0010};
    tbl[1]  = '{4'b0111, 4'b0010, 4'b0010};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0100};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1001, 4'b0001, 4'b1000};
    tbl[5]  = '{4'b1001, 4'b0001, 4'b1000};
    tbl[6]  = '{4'b1001, 4'b0001, 4'b1000};
    tbl[7]  = '{4'b1001, 4'b0001, 4'b1000};
    tbl[8]  = '{4'b1001, 4'b1000, 4'b0001};
    tbl[9]  = '{4'b1000, 4'b1000, 4'b1000};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].req);
      chk($sformatf("tbl%0d_fix", i), 32'(g_fix), 32'(tbl[i].exp_fix));
      chk($sformatf("tbl%0d_rr", i), 32'(g_rr), 32'(tbl[i].exp_rr));
    end

    // Round-robin rotation: each owner withdraws for one cycle after being granted.
    rr_req_seq[0] = 4'b1111; rr_req_seq[1] = 4'b1110; rr_req_seq[2] = 4'b1101;
    rr_req_seq[3] = 4'b1011; rr_req_seq[4] = 4'b0111;
    exp_rr_seq[0] = 0; exp_rr_seq[1] = 1; exp_rr_seq[2] = 2; exp_rr_seq[3] = 3; exp_rr_seq[4] = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(rr_req_seq[i]);
      chk($sformatf("rr_rotate%0d", i), 32'(id_rr), 32'(exp_rr_seq[i]));
    end
    cycle(4'b0000);

    // A lone requester keeps its grant across several hold windows.
    for (int i = 0; i < 3 * MAXH; i++) begin
      cycle(4'b0001);
      chk("lone_owner_keeps", 32'(g_fix), 32'h1);
    end

    // Asynchronous reset mid-grant.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fix_grant", 32'(g_fix), 32'h0);
    chk("async_rst_fix_busy", 32'(b_fix), 32'h0);
    chk("async_rst_rr_grant", 32'(g_rr), 32'h0);
    chk("async_rst_rr_busy", 32'(b_rr), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1000);
    chk("post_rst_rr_grant", 32'(g_rr), 32'h8);
    cycle(4'b0000);

    r = 4'b0000;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cycle(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..16).
REQ-002 The block SHALL have parameter RR_MODE, default 0, meaning 0 = fixed priority and 1 = round-robin.
REQ-003 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive grant cycles before forced re-arbitration (0 = unlimited).
REQ-004 The block SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, width N, with bit i being the request from requester i.
REQ-007 The block SHALL have port grant, output, width N, a registered one-hot (or all-zero) grant.
REQ-008 The block SHALL have port grant_id, output, width $clog2(N), a registered index of the granted requester (0 when idle).
REQ-009 The block SHALL have port busy, output, width 1, registered and high while any grant is active.

Function
REQ-010 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-011 In IDLE with req == 0, the block SHALL remain in IDLE with grant = 0.
REQ-012 In IDLE with req != 0, the block SHALL select a winner and, on the next edge, enter GRANT with grant[winner] = 1, grant_id = winner and busy = 1 (one-cycle latency).
REQ-013 In fixed mode (RR_MODE = 0), the lowest index SHALL have highest priority.
REQ-014 In round-robin mode (RR_MODE = 1), the search SHALL start at index (last_id+1) mod N and wrap around; last_id SHALL update on every new grant.
REQ-015 In GRANT, the grant SHALL be held while req[grant_id] stays high and the hold limit is not reached; other requests SHALL NOT preempt it.
REQ-016 When req[grant_id] drops in GRANT, the block SHALL arbitrate among the remaining req bits in that same cycle and, on the next edge, either grant the new winner (staying in GRANT) or go to IDLE with grant = 0; no idle bubble SHALL be inserted between owners.
REQ-017 hold_cnt SHALL clear on each new grant and increment each cycle in GRANT, saturating at MAX_HOLD.
REQ-018 If MAX_HOLD != 0, hold_cnt == MAX_HOLD-1 and any other req bit is set, the block SHALL force re-arbitration with the current owner excluded and switch the grant on the next edge.
REQ-019 If the hold limit is reached and no other request is pending, the owner SHALL keep the grant and hold_cnt SHALL restart from 0.
REQ-020 Requests that are withdrawn before being granted SHALL be ignored, with no queuing or memory of them.
REQ-021 The grant SHALL always be one-hot or zero, and grant_id SHALL always equal the index of the set grant bit.
REQ-022 When req changes in the same cycle that the owner drops, arbitration SHALL use the req value present in that cycle.

Reset
REQ-023 While rst_n == 0, the block SHALL immediately force state = IDLE, grant = 0, grant_id = 0, busy = 0, hold_cnt = 0 and last_id = N-1, so that round-robin starts at index 0.
REQ-024 Reset asserted in GRANT SHALL drop the grant asynchronously; after release, arbitration SHALL restart from IDLE on the first edge at which req != 0.

Verification (N = 4, MAX_HOLD = 4)
REQ-025 Fixed-priority scenario: with RR_MODE = 0, req = 4'b0110 from IDLE -> the next edge gives grant = 4'b0010 and grant_id = 1; raising req[0] later SHALL NOT preempt it.
REQ-026 Handover scenario: with owner 1 and req going 4'b0110 -> 4'b0100 -> the next edge gives grant = 4'b0100 with no zero cycle between owners.
REQ-027 Round-robin scenario: with RR_MODE = 1, req = 4'b1111 held and each owner dropping after one cycle -> grants SHALL go 0, 1, 2, 3, 0 in order.
REQ-028 Hold-limit scenario: with req = 4'b0011 held continuously and owner 0 -> after 4 grant cycles the grant moves to 1; with req = 4'b0001 only, owner 0 keeps the grant indefinitely.
REQ-029 Reset scenario: rst_n pulsed low mid-GRANT -> grant = 0 and busy = 0 before the next clock edge; after release with req = 4'b1000 in RR mode -> grant = 4'b1000.
REQ-030 Assertion scenario: the one-hot check and the grant_id/grant consistency check SHALL hold in every cycle across a random-request run of at least 10,000 cycles.
